// File: rtl/bio_ctrl.sv
// bio_ctrl: board I/O controller on the CPU I/O bus.
// Drives LEDs and eight 7-seg digits, samples switches and debounced keys,
// latches key presses and raises a maskable level interrupt.
// Optional macro BIO_HEX_EN: builds the hex register and 7-seg decoders;
// without it reg 1 reads 0 and hex_n stays blank.
module bio_ctrl #(
  parameter int NUM_LED    = 8,
  parameter int NUM_SW     = 8,
  parameter int NUM_KEY    = 3,
  parameter int DEB_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               wr,
  input  logic [1:0]         addr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               irq,
  output logic [NUM_LED-1:0] led,
  output logic [55:0]        hex_n,
  input  logic [NUM_SW-1:0]  sw,
  input  logic [NUM_KEY-1:0] key_n
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic                        wr_en;
  logic [NUM_LED-1:0]          led_q, led_d;
  logic [NUM_KEY-1:0]          ie_q, ie_d;
  logic [NUM_KEY-1:0]          flags_q, flags_d;
  logic                        irq_q, irq_d;
  logic [NUM_SW-1:0]           sw_s1_q, sw_s2_q;
  logic [NUM_KEY-1:0]          ks1_q, ks2_q;
  logic [NUM_KEY-1:0]          deb_q, deb_d;
  logic [NUM_KEY-1:0]          press;
  logic [NUM_KEY-1:0]          clr;
  logic [NUM_KEY-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [31:0]                 hex_rd;
  logic                        unused_data;

  assign wr_en       = en & wr;
  assign unused_data = ^data_in;

  // Per-key debounce: count while sync input differs from deb, commit on the last count
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    press = '0;
    for (int k = 0; k < NUM_KEY; k++) begin
      if (ks2_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        deb_d[k] = ks2_q[k];
        cnt_d[k] = '0;
        press[k] = ks2_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  // Bus writes, sticky press flags (a same-cycle press beats W1C) and irq level
  always_comb begin
    led_d   = led_q;
    ie_d    = ie_q;
    clr     = '0;
    if (wr_en && addr == 2'd0) led_d = data_in[NUM_LED-1:0];
    if (wr_en && addr == 2'd3) ie_d  = data_in[NUM_KEY-1:0];
    if (wr_en && addr == 2'd2) clr   = data_in[NUM_KEY-1:0];
    flags_d = (flags_q & ~clr) | press;
    irq_d   = |(flags_q & ie_q);
  end

  // Control state, synchronisers and debouncers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      ie_q    <= '0;
      flags_q <= '0;
      irq_q   <= 1'b0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      ks1_q   <= '0;
      ks2_q   <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      led_q   <= led_d;
      ie_q    <= ie_d;
      flags_q <= flags_d;
      irq_q   <= irq_d;
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      ks1_q   <= ~key_n;
      ks2_q   <= ks1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BIO_HEX_EN
  logic [31:0] hex_q, hex_d;
  logic        hex_vld_q, hex_vld_d;
  logic [55:0] hex_n_q, hex_n_d;

  // Active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  // Hex register; decode from next value so the pattern lands with the write
  always_comb begin
    hex_d     = hex_q;
    hex_vld_d = hex_vld_q;
    if (wr_en && addr == 2'd1) begin
      hex_d     = data_in;
      hex_vld_d = 1'b1;
    end
    hex_n_d = '1;
    if (hex_vld_d) begin
      for (int d = 0; d < 8; d++) hex_n_d[7*d +: 7] = seg7(hex_d[4*d +: 4]);
    end
  end

  // Hex state; hex_vld holds the display blank until the first write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q     <= '0;
      hex_vld_q <= 1'b0;
      hex_n_q   <= '1;
    end else begin
      hex_q     <= hex_d;
      hex_vld_q <= hex_vld_d;
      hex_n_q   <= hex_n_d;
    end
  end

  assign hex_rd = hex_q;
  assign hex_n  = hex_n_q;
`else
  assign hex_rd = '0;
  assign hex_n  = '1;
`endif

  // Read mux, combinational from addr, unused bits zero
  always_comb begin
    data_out = '0;
    case (addr)
      2'd0: begin
        data_out[NUM_SW-1:0]    = sw_s2_q;
        data_out[16 +: NUM_KEY] = deb_q;
      end
      2'd1:    data_out                = hex_rd;
      2'd2:    data_out[NUM_KEY-1:0]   = flags_q;
      default: data_out[NUM_KEY-1:0]   = ie_q;
    endcase
  end

  assign led = led_q;
  assign irq = irq_q;

endmodule

// File: tb/tb_bio_ctrl.sv
// tb_bio_ctrl: directed bench for bio_ctrl with an in-bench reference model
// compared every cycle, plus literal expectations at key points.
module tb_bio_ctrl;
  localparam int NL = 8, NS = 16, NK = 3, DEB = 4;

  logic          clk = 1'b0, rst = 1'b1, en = 1'b0, wr = 1'b0;
  logic [1:0]    addr = '0;
  logic [31:0]   data_in = '0, data_out;
  logic          irq;
  logic [NL-1:0] led;
  logic [55:0]   hex_n;
  logic [NS-1:0] sw = '0;
  logic [NK-1:0] key_n = '1;

  int nerr = 0, nchk = 0;

  bio_ctrl #(.NUM_LED(NL), .NUM_SW(NS), .NUM_KEY(NK), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .irq(irq), .led(led), .hex_n(hex_n), .sw(sw), .key_n(key_n));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic [NL-1:0] m_led;
  logic [NK-1:0] m_ie, m_flags, m_deb;
  logic          m_irq, m_vld;
  logic [31:0]   m_hex;
  logic [NS-1:0] m_sw1, m_sw2;
  logic [DEB+1:0] inh [NK];   // inh[k][j]: key k pressed-level sampled j edges ago

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_led = '0; m_ie = '0; m_flags = '0; m_deb = '0; m_irq = 0; m_vld = 0;
      m_hex = '0; m_sw1 = '0; m_sw2 = '0;
      for (int k = 0; k < NK; k++) inh[k] = '0;
    end else begin
      logic [NK-1:0] prs, clr;
      prs = '0; clr = '0;
      m_irq = |(m_flags & m_ie);
      for (int k = 0; k < NK; k++) begin
        bit stable;
        inh[k] = {inh[k][DEB:0], ~key_n[k]};
        // deb flips once the synced level has differed from it for DEB straight cycles
        stable = 1;
        for (int j = 2; j <= DEB + 1; j++) if (inh[k][j] == m_deb[k]) stable = 0;
        if (stable) begin
          m_deb[k] = ~m_deb[k];
          prs[k] = m_deb[k];
        end
      end
      if (en && wr && addr == 2) clr = data_in[NK-1:0];
      m_flags = (m_flags & ~clr) | prs;
      m_sw2 = m_sw1; m_sw1 = sw;
      if (en && wr && addr == 0) m_led = data_in[NL-1:0];
      if (en && wr && addr == 3) m_ie = data_in[NK-1:0];
`ifdef BIO_HEX_EN
      if (en && wr && addr == 1) begin m_hex = data_in; m_vld = 1; end
`endif
    end
  end

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      0: begin r[NS-1:0] = m_sw2; r[16 +: NK] = m_deb; end
      1: r = m_hex;
      2: r[NK-1:0] = m_flags;
      default: r[NK-1:0] = m_ie;
    endcase
    return r;
  endfunction

  function automatic logic [55:0] m_hexn();
    logic [55:0] h;
    h = '1;
    if (m_vld) for (int d = 0; d < 8; d++) h[7*d +: 7] = seg_tab[m_hex[4*d +: 4]];
    return h;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    nchk++;
    if (led !== m_led || irq !== m_irq || hex_n !== m_hexn() || data_out !== m_read(addr)) begin
      nerr++;
      $display("FAIL model t=%0t: led=%h/%h irq=%b/%b hex_n=%h/%h rd[%0d]=%h/%h (act/exp)",
               $time, led, m_led, irq, m_irq, hex_n, m_hexn(), addr, data_out, m_read(addr));
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wreg(input logic [1:0] a, input logic [31:0] d);
    en = 1; wr = 1; addr = a; data_in = d;
    tick();
    en = 0; wr = 0;
  endtask

  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] exp);
    addr = a; #1;
    chk(nm, data_out, exp);
  endtask

  initial begin
    tick(2);
    rst = 0;
    tick();
    // 1: reset state
    rd("rst_r0", 0, 0); rd("rst_r1", 1, 0); rd("rst_r2", 2, 0); rd("rst_r3", 3, 0);
    chk("rst_led", led, 0);
    chk("rst_hex", hex_n, 56'hFF_FFFF_FFFF_FFFF);
    chk("rst_irq", irq, 0);

    // 2: LEDs, ignored write with en=0, switch sync latency
    wreg(0, 32'hA5);
    chk("led_a5", led, 8'hA5);
    wr = 1; en = 0; addr = 0; data_in = 32'h3C; tick(); wr = 0;
    chk("led_en0", led, 8'hA5);
    sw = 16'h1234;
    tick();
    rd("sw_1edge", 0, 0);
    tick();
    rd("sw_2edge", 0, 32'h1234);
    sw = 0; tick(2);

    // 3: short glitch ignored, held press debounced after 2+DEB edges
    key_n[1] = 0; tick(3); key_n[1] = 1; tick(10);
    rd("glitch_flags", 2, 0);
    key_n[1] = 0; tick(5);
    rd("deb_5edge", 0, 0);
    tick();
    rd("deb_6edge", 0, 32'h0002_0000);
    rd("press_flag", 2, 3'b010);
    tick(4); key_n[1] = 1; tick(10);
    rd("release_keeps", 2, 3'b010);

    // 4: interrupt enable, W1C, set beats clear
    wreg(3, 3'b010);
    chk("irq_lag", irq, 0);
    tick();
    chk("irq_on", irq, 1);
    wreg(2, 3'b010);
    chk("irq_hold", irq, 1);
    tick();
    chk("irq_off", irq, 0);
    rd("flag_clr", 2, 0);
    key_n[1] = 0; tick(5);
    wreg(2, 3'b010);          // clear lands on the press edge
    rd("set_wins", 2, 3'b010);
    tick();
    chk("irq_again", irq, 1);
    key_n[1] = 1; tick(10);

    // 5: hex display
    wreg(1, 32'h0000_00F1);
`ifdef BIO_HEX_EN
    chk("dig0_1", hex_n[6:0], 7'b1111001);
    chk("dig1_F", hex_n[13:7], 7'b0001110);
    chk("dig2_0", hex_n[20:14], 7'b1000000);
    rd("hex_rd", 1, 32'h0000_00F1);
    wreg(1, 32'h89AB_CDEF);
    rd("hex_rd2", 1, 32'h89AB_CDEF);
`else
    chk("hex_off_blank", hex_n, 56'hFF_FFFF_FFFF_FFFF);
    rd("hex_off_rd", 1, 0);
`endif

    // 6: reset mid-debounce, key kept held
    wreg(2, 3'b111);
    key_n[0] = 0; tick(4);
    rst = 1; #1;
    rd("rst_mid_flags", 2, 0);
    rd("rst_mid_deb", 0, 0);
    chk("rst_mid_led", led, 0);
    tick();
    rst = 0;
    tick(5);
    rd("post_rst_5", 2, 0);
    tick();
    rd("post_rst_6", 2, 3'b001);
    key_n[0] = 1; tick(8);

    // mixed traffic with model checking each cycle
    for (int i = 0; i < 40; i++) begin
      sw = NS'($urandom);
      if (i % 7 == 3) key_n[2] = ~key_n[2];
      wreg(2'(i), $urandom);
      addr = 2'($urandom); tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
